// File: rtl/alu_arbiter_if.sv
// Requester/response bundle for alu_arbiter; master = issuing agents and consumer, slave = arbiter.
// rsp_zero exists only when ALU_ZERO_FLAG_EN is defined.
interface alu_arbiter_if;
   logic       req0_valid;
   logic       req0_ready;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic [2:0] req0_op;
   logic       req1_valid;
   logic       req1_ready;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic [2:0] req1_op;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [3:0] rsp_result;
`ifdef ALU_ZERO_FLAG_EN
   logic       rsp_zero;

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_zero,
      input  rsp_ready
   );
`else
   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result,
      output rsp_ready
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result,
      input  rsp_ready
   );
`endif
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one 4-bit ALU between two requesters: IDLE grant -> EXEC -> RESP hold.
// Optional ALU_ZERO_FLAG_EN adds a registered rsp_zero flag alongside rsp_result.
module alu_arbiter (
   input  logic          clk,
   input  logic          rst,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] op;
      logic       id;
   } op_req_t;

   state_t     state, state_nxt;
   logic       last_grant;
   logic [1:0] vld;
   logic [1:0] rdy;
   logic       gnt_any;
   logic       gnt_id;
   logic       xfer;
   op_req_t    req_mux;
   op_req_t    req_q;
   logic [3:0] alu_res;
   logic [3:0] res_q;
   logic       id_q;
`ifdef ALU_ZERO_FLAG_EN
   logic       zero_q;
`endif

   assign vld = {bus.req1_valid, bus.req0_valid};

   // Contended cycles go to whoever did not win last; otherwise the lone requester.
   always_comb begin
      gnt_any = |vld;
      if (&vld) gnt_id = ~last_grant;
      else      gnt_id = vld[1];
   end

   always_comb begin
      req_mux = '0;
      if (gnt_id) begin
         req_mux.a  = bus.req1_a;
         req_mux.b  = bus.req1_b;
         req_mux.op = bus.req1_op;
         req_mux.id = 1'b1;
      end else begin
         req_mux.a  = bus.req0_a;
         req_mux.b  = bus.req0_b;
         req_mux.op = bus.req0_op;
         req_mux.id = 1'b0;
      end
   end

   // Ready is gated by rst so nothing transfers in the reset cycle.
   always_comb begin
      state_nxt = state;
      rdy       = 2'b00;
      case (state)
         IDLE: begin
            if (gnt_any && !rst) begin
               rdy       = gnt_id ? 2'b10 : 2'b01;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign xfer = |rdy;

   always_comb begin
      alu_res = 4'b0000;
      case (req_q.op)
         3'b000: alu_res = req_q.a + req_q.b;
         3'b001: alu_res = req_q.a - req_q.b;
         3'b010: alu_res = req_q.a & req_q.b;
         3'b011: alu_res = req_q.a | req_q.b;
         3'b100: alu_res = req_q.a ^ req_q.b;
         3'b101: alu_res = ~(req_q.a & req_q.b);
         3'b110: alu_res = ~(req_q.a | req_q.b);
         default: alu_res = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         req_q      <= '0;
         res_q      <= 4'b0000;
         id_q       <= 1'b0;
      end else begin
         state <= state_nxt;
         if (xfer) begin
            req_q      <= req_mux;
            last_grant <= gnt_id;
         end
         if (state == EXEC) begin
            res_q <= alu_res;
            id_q  <= req_q.id;
         end
      end
   end

`ifdef ALU_ZERO_FLAG_EN
   always_ff @(posedge clk) begin
      if (rst)                 zero_q <= 1'b0;
      else if (state == EXEC)  zero_q <= (alu_res == 4'b0000);
   end

   assign bus.rsp_zero = zero_q;
`endif

   assign bus.req0_ready = rdy[0];
   assign bus.req1_ready = rdy[1];
   assign bus.rsp_valid  = (state == RESP);
   assign bus.rsp_result = res_q;
   assign bus.rsp_id     = id_q;

endmodule
